mem_tracked_arbiter: RTL and testbench
======================================

# mem_tracked_arbiter

Parametrised N-to-1 memory arbiter between several master ports and one in-order memory slave. It arbitrates requests by fixed priority or round-robin and holds the grant stable across slave back-pressure. An outstanding-transaction FIFO of master indices routes each in-order response back to its requester. Requests are throttled when the FIFO is full, and a response arriving with nothing outstanding is flagged as a protocol error.

## Interface
- CNT, 2, number of master ports (≥1; index width max(1,$clog2(CNT)))
- QUEUE_DEPTH, 4, max outstanding slave transactions (≥1, any integer, all entries usable)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- master_req[CNT]  decoupled.in  intf  request from each master
- master_resp[CNT]  decoupled.out  intf  response to each master
- slave_req  decoupled.out  intf  request to memory
- slave_resp  decoupled.in  intf  response from memory, in request order
- outstanding  out  $clog2(QUEUE_DEPTH+1)  current FIFO occupancy
- resp_err  out  1  sticky: response received with empty FIFO

## Operation
- Reset (rst_n low, asynchronous): FIFO empty, head/tail 0, outstanding 0, grant lock clear, round-robin pointer 0, resp_err 0. Outputs during reset: slave_req.valid 0, slave_resp.ready 0, all master_req.ready 0, all master_resp.valid 0.
- Grant selection (lock clear): among asserted master_req[i].valid, choose winner per arbitration mode. slave_req.valid = any valid && !full; slave_req.data = winner data.
- Only the winner's master_req.ready may be 1; it equals slave_req.fire().
- Grant lock: if slave_req.valid && !slave_req.ready, latch winner; next cycles force that winner (its valid is guaranteed held by decoupled rules) until fire. Lock clears on fire.
- Full (outstanding == QUEUE_DEPTH): slave_req.valid 0, no grant, lock not set. A pop in the same cycle does not unblock (no resp->req combinational path).
- On slave_req.fire(): push winner index at tail, tail wraps QUEUE_DEPTH-1 → 0.
- Response routing: master_resp[head].valid = slave_resp.valid; data broadcast to all; slave_resp.ready = master_resp[head].ready when non-empty. On fire: pop, head wraps.
- Empty FIFO with slave_resp.valid: slave_resp.ready 0, resp_err set, held until reset.
- Simultaneous push+pop: occupancy unchanged, both pointers advance.

## Timing
- Request path combinational: master valid → slave_req.valid same cycle; zero added latency.
- Response path combinational from registered head index; zero added latency.
- Lock and round-robin pointer update on the fire edge and take effect the next cycle.
- outstanding reflects pushes and pops from the previous edge (registered).

## Configuration
- MEM_ARBITER_ROUND_ROBIN_EN defined: round-robin arbitration. After a fire by master k, priority pointer = (k+1) mod CNT. The winner is the first valid at or after the pointer, wrapping.
- Undefined: fixed priority, lowest index wins; pointer logic absent.

## Structure
- Shared package mem_pkg: master index type, queue index type, and occupancy-width helper localparams.
- Sub-module idx_fifo (parameterised width/depth, count-based full/empty, push/pop/head outputs) holds the outstanding-index queue.
- Arbitration and lock logic stays in mem_tracked_arbiter.

## Test plan
- CNT=2, fixed priority, masters 0 and 1 valid, slave ready → master 0 fires first, then 1. Responses A,B route to master 0 then 1.
- Slave ready low 3 cycles while master 0 valid, then master 1 also valid in cycle 2 → slave_req.data stays master 0 payload until fire.
- QUEUE_DEPTH=3, slave_resp idle, 4 back-to-back requests → 3 fire, outstanding=3, 4th held (valid 0). One response pop → 4th fires next cycle.
- Round-robin on, CNT=3, all valid continuously → fire order 0,1,2,0,1,2.
- slave_resp.valid with outstanding=0 → slave_resp.ready 0, resp_err 1 and stays 1 until rst_n low.
- rst_n asserted mid-burst with outstanding=2 → immediately outstanding 0, all valids/readies 0. After release, the next request pushes at index 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared width helpers for mem_tracked_arbiter and its outstanding-index FIFO.
package mem_pkg;

  // Width of an index that can address n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of an occupancy counter that must reach depth inclusive.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/idx_fifo.sv
// Count-based circular FIFO holding master indices of in-flight slave transactions.
module idx_fifo
  import mem_pkg::*;
#(
  parameter  int unsigned WIDTH = 1,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = idx_width(DEPTH),
  localparam int unsigned CNT_W = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap at DEPTH-1 so non-power-of-two depths use every entry.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_tail] <= i_push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= wrap_inc(r_tail);
      if (i_pop)  r_head <= wrap_inc(r_head);
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (!i_push && i_pop) r_count <= r_count - 1'b1;
    end
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/mem_tracked_arbiter.sv
// N-to-1 memory arbiter with grant lock and in-order response routing.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module mem_tracked_arbiter
  import mem_pkg::*;
#(
  parameter  int unsigned CNT         = 2,
  parameter  int unsigned QUEUE_DEPTH = 4,
  parameter  int unsigned DATA_W      = 32,
  localparam int unsigned IDX_W       = idx_width(CNT),
  localparam int unsigned OCC_W       = occ_width(QUEUE_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CNT-1:0]             i_master_req_valid,
  output logic [CNT-1:0]             o_master_req_ready,
  input  logic [CNT-1:0][DATA_W-1:0] i_master_req_data,
  output logic [CNT-1:0]             o_master_resp_valid,
  input  logic [CNT-1:0]             i_master_resp_ready,
  output logic [CNT-1:0][DATA_W-1:0] o_master_resp_data,
  output logic                       o_slave_req_valid,
  input  logic                       i_slave_req_ready,
  output logic [DATA_W-1:0]          o_slave_req_data,
  input  logic                       i_slave_resp_valid,
  output logic                       o_slave_resp_ready,
  input  logic [DATA_W-1:0]          i_slave_resp_data,
  output logic [OCC_W-1:0]           o_outstanding,
  output logic                       o_resp_err
);

  logic [IDX_W-1:0] w_pick;
  logic [IDX_W-1:0] w_grant;
  logic [IDX_W-1:0] w_head;
  logic [IDX_W-1:0] r_lock_idx;
  logic [OCC_W-1:0] w_count;
  logic             w_any;
  logic             w_full;
  logic             w_empty;
  logic             w_sreq_fire;
  logic             w_sresp_fire;
  logic             r_lock;
  logic             r_resp_err;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_rr_ptr <= '0;
    else if (w_sreq_fire) r_rr_ptr <= (w_grant == IDX_W'(CNT - 1)) ? '0 : w_grant + 1'b1;
  end
`endif

  always_comb begin : arb
    logic [IDX_W-1:0] w_j;
    logic             w_found;
    w_pick  = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int unsigned k = 0; k < CNT; k++) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      w_j = IDX_W'((32'(r_rr_ptr) + k) % CNT);
`else
      w_j = IDX_W'(k);
`endif
      if (!w_found && i_master_req_valid[w_j]) begin
        w_found = 1'b1;
        w_pick  = w_j;
      end
    end
  end

  assign w_any   = |i_master_req_valid;
  assign w_grant = r_lock ? r_lock_idx : w_pick;

  // Full blocks on registered occupancy only, so a same-cycle pop cannot unblock.
  assign o_slave_req_valid = rst_n && !w_full &&
                             (r_lock ? i_master_req_valid[r_lock_idx] : w_any);
  assign o_slave_req_data  = i_master_req_data[w_grant];
  assign w_sreq_fire       = o_slave_req_valid && i_slave_req_ready;

  always_comb begin
    o_master_req_ready = '0;
    if (w_sreq_fire) o_master_req_ready[w_grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_sreq_fire) begin
      r_lock <= 1'b0;
    end else if (o_slave_req_valid) begin
      r_lock     <= 1'b1;
      r_lock_idx <= w_grant;
    end
  end

  idx_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_idx_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_sreq_fire),
    .i_push_data (w_grant),
    .i_pop       (w_sresp_fire),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign o_slave_resp_ready = rst_n && !w_empty && i_master_resp_ready[w_head];
  assign w_sresp_fire       = i_slave_resp_valid && o_slave_resp_ready;
  assign o_master_resp_data = {CNT{i_slave_resp_data}};

  always_comb begin
    o_master_resp_valid = '0;
    if (rst_n && !w_empty) o_master_resp_valid[w_head] = i_slave_resp_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_resp_err <= 1'b0;
    else if (i_slave_resp_valid && w_empty)  r_resp_err <= 1'b1;
  end

  assign o_outstanding = w_count;
  assign o_resp_err    = r_resp_err;

endmodule

// File: tb/tb_mem_tracked_arbiter.sv
// Bench for mem_tracked_arbiter: queue-based model checked every cycle plus directed literals.
module tb_mem_tracked_arbiter;
  localparam int CNT = 3;
  localparam int QD  = 3;
  localparam int DW  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [CNT-1:0]         mreq_v, mreq_r, mresp_v, mresp_r;
  logic [CNT-1:0][DW-1:0] mreq_d, mresp_d;
  logic                   sreq_v, sreq_r, sresp_v, sresp_r;
  logic [DW-1:0]          sreq_d, sresp_d;
  logic [1:0]             outst;
  logic                   err;

  always #5 clk = ~clk;

  mem_tracked_arbiter #(
    .CNT         (CNT),
    .QUEUE_DEPTH (QD),
    .DATA_W      (DW)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_master_req_valid  (mreq_v),
    .o_master_req_ready  (mreq_r),
    .i_master_req_data   (mreq_d),
    .o_master_resp_valid (mresp_v),
    .i_master_resp_ready (mresp_r),
    .o_master_resp_data  (mresp_d),
    .o_slave_req_valid   (sreq_v),
    .i_slave_req_ready   (sreq_r),
    .o_slave_req_data    (sreq_d),
    .i_slave_resp_valid  (sresp_v),
    .o_slave_resp_ready  (sresp_r),
    .i_slave_resp_data   (sresp_d),
    .o_outstanding       (outst),
    .o_resp_err          (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: queue of requesters awaiting responses, stalled offer, priority pointer, error flag.
  int q[$];
  int held = -1;
  int rr = 0;
  bit m_err = 1'b0;
  int fire_log[$];
  int resp_m[$];
  logic [DW-1:0] resp_d[$];

  int ck_w;
  bit ck_ev, ck_ef, ck_esr, ck_empty, ck_pop;
  logic [CNT-1:0] ck_er, ck_erv;

  function automatic int pick();
    for (int k = 0; k < CNT; k++) begin
      int j;
      j = (rr + k) % CNT;
      if (mreq_v[j]) return j;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_sreq_valid", sreq_v, 0);
      chk("rst_sresp_ready", sresp_r, 0);
      chk("rst_mreq_ready", mreq_r, 0);
      chk("rst_mresp_valid", mresp_v, 0);
      chk("rst_outstanding", outst, 0);
      chk("rst_err", err, 0);
      q.delete();
      held = -1;
      rr = 0;
      m_err = 1'b0;
    end else begin
      ck_w  = (held >= 0) ? held : pick();
      ck_ev = (q.size() < QD) && (ck_w >= 0) && mreq_v[ck_w];
      chk("sreq_valid", sreq_v, ck_ev);
      if (ck_ev) chk("sreq_data", sreq_d, mreq_d[ck_w]);
      ck_ef = ck_ev && sreq_r;
      ck_er = '0;
      if (ck_ef) ck_er[ck_w] = 1'b1;
      chk("mreq_ready", mreq_r, ck_er);

      ck_empty = (q.size() == 0);
      ck_erv = '0;
      ck_esr = 1'b0;
      if (!ck_empty) begin
        ck_erv[q[0]] = sresp_v;
        ck_esr = mresp_r[q[0]];
      end
      chk("mresp_valid", mresp_v, ck_erv);
      chk("sresp_ready", sresp_r, ck_esr);
      for (int i = 0; i < CNT; i++)
        if (ck_erv[i]) chk("mresp_data", mresp_d[i], sresp_d);
      chk("outstanding", outst, q.size());
      chk("resp_err", err, m_err);

      if (sreq_v && sreq_r)
        for (int i = 0; i < CNT; i++) if (mreq_r[i]) fire_log.push_back(i);
      for (int i = 0; i < CNT; i++)
        if (mresp_v[i] && mresp_r[i]) begin
          resp_m.push_back(i);
          resp_d.push_back(mresp_d[i]);
        end

      ck_pop = !ck_empty && sresp_v && ck_esr;
      if (ck_pop) void'(q.pop_front());
      if (ck_ef) begin
        q.push_back(ck_w);
        held = -1;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        rr = (ck_w + 1) % CNT;
`endif
      end else if (ck_ev) begin
        held = ck_w;
      end
      if (sresp_v && ck_empty) m_err = 1'b1;
    end
  end

  // Master stimulus: each master presents m_cnt[i] requests with incrementing payloads.
  int m_cnt [CNT];
  logic [DW-1:0] m_data [CNT];
  bit auto_resp = 1'b0;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  int exp_ord [6] = '{0, 1, 2, 0, 1, 2};
`else
  int exp_ord [6] = '{0, 0, 1, 1, 2, 2};
`endif

  task automatic drive();
    for (int i = 0; i < CNT; i++) begin
      mreq_v[i] = (m_cnt[i] > 0);
      mreq_d[i] = m_data[i];
    end
  endtask

  task automatic cyc();
    logic [CNT-1:0] f;
    @(negedge clk);
    f = (sreq_v && sreq_r) ? mreq_r : '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < CNT; i++)
      if (f[i]) begin
        m_cnt[i]--;
        m_data[i] = m_data[i] + 1'b1;
      end
    drive();
    if (auto_resp) begin
      sresp_v = (q.size() > 0);
      sresp_d = sresp_d + 1'b1;
    end
  endtask

  initial begin
    mreq_v = '0; mreq_d = '0; sreq_r = 1'b0; sresp_v = 1'b0; sresp_d = '0; mresp_r = '1;
    m_cnt = '{default: 0};
    m_data[0] = 8'hA0; m_data[1] = 8'hB0; m_data[2] = 8'hE0;
    drive();
    #1 rst_n = 1'b0;
    #1;
    chk("lit_rst_outstanding", outst, 0);
    chk("lit_rst_sreq_valid", sreq_v, 0);
    chk("lit_rst_err", err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Two masters, slave ready: fire order then in-order response routing.
    m_cnt[0] = 1; m_cnt[1] = 1; sreq_r = 1'b1; drive();
    cyc(); cyc();
    chk("lit_A_outstanding", outst, 2);
    chk("lit_A_fire0", fire_log[0], 0);
    chk("lit_A_fire1", fire_log[1], 1);
    sresp_v = 1'b1; sresp_d = 8'h11; cyc();
    sresp_d = 8'h22; cyc();
    sresp_v = 1'b0;
    chk("lit_A_resp0_m", resp_m[0], 0);
    chk("lit_A_resp0_d", resp_d[0], 8'h11);
    chk("lit_A_resp1_m", resp_m[1], 1);
    chk("lit_A_resp1_d", resp_d[1], 8'h22);

    // Stall with master 1 offered first; master 0 joins mid-stall and must not steal the grant.
    sreq_r = 1'b0; m_cnt[1] = 1; drive();
    cyc();
    m_cnt[0] = 1; drive();
    cyc();
    chk("lit_B_hold_data2", sreq_d, 8'hB1);
    cyc();
    chk("lit_B_hold_data3", sreq_d, 8'hB1);
    chk("lit_B_hold_valid", sreq_v, 1);
    sreq_r = 1'b1;
    cyc(); cyc();
    chk("lit_B_fire2", fire_log[2], 1);
    chk("lit_B_fire3", fire_log[3], 0);
    chk("lit_B_outstanding", outst, 2);

    // Asynchronous reset with two outstanding.
    sreq_r = 1'b0; m_cnt[2] = 1; drive();
    #2 rst_n = 1'b0;
    #1;
    chk("lit_R_outstanding", outst, 0);
    chk("lit_R_sreq_valid", sreq_v, 0);
    chk("lit_R_mreq_ready", mreq_r, 0);
    chk("lit_R_sresp_ready", sresp_r, 0);
    sresp_v = 1'b1;
    #1 chk("lit_R_mresp_valid", mresp_v, 0);
    cyc(); cyc();
    sresp_v = 1'b0; rst_n = 1'b1; sreq_r = 1'b1;
    cyc();
    chk("lit_R_fire_cnt", fire_log.size(), 5);
    chk("lit_R_fire4", fire_log[4], 2);
    sresp_v = 1'b1; sresp_d = 8'h33; cyc();
    sresp_v = 1'b0;
    chk("lit_R_resp_m", resp_m[2], 2);
    chk("lit_R_resp_d", resp_d[2], 8'h33);

    // Queue full: three fire, fourth held; a pop unblocks only on the next cycle.
    m_cnt[0] = 4; drive();
    cyc(); cyc(); cyc();
    chk("lit_C_full_outstanding", outst, 3);
    chk("lit_C_full_sreq_valid", sreq_v, 0);
    cyc();
    chk("lit_C_held_cnt", fire_log.size(), 8);
    sresp_v = 1'b1; sresp_d = 8'h44;
    #1 chk("lit_C_pop_no_unblock", sreq_v, 0);
    cyc();
    sresp_v = 1'b0;
    chk("lit_C_after_pop_outst", outst, 2);
    chk("lit_C_after_pop_valid", sreq_v, 1);
    cyc();
    chk("lit_C_fire_cnt", fire_log.size(), 9);
    chk("lit_C_outstanding", outst, 3);
    sresp_v = 1'b1; sresp_d = 8'h50;
    repeat (3) cyc();
    sresp_v = 1'b0;
    chk("lit_C_drained", outst, 0);

    // All three masters valid continuously from a fresh reset.
    rst_n = 1'b0; cyc(); cyc(); rst_n = 1'b1;
    m_cnt[0] = 2; m_cnt[1] = 2; m_cnt[2] = 2; drive();
    auto_resp = 1'b1;
    for (int t = 0; t < 40 && fire_log.size() < 15; t++) cyc();
    chk("lit_D_fire_cnt", fire_log.size(), 15);
    for (int i = 0; i < 6; i++) chk($sformatf("lit_D_order%0d", i), fire_log[9 + i], exp_ord[i]);
    for (int t = 0; t < 10 && q.size() > 0; t++) cyc();
    auto_resp = 1'b0; sresp_v = 1'b0;
    #1 chk("lit_D_drained", outst, 0);

    // Response with nothing outstanding: refused and flagged until reset.
    sresp_v = 1'b1; sresp_d = 8'h66;
    #1;
    chk("lit_E_sresp_ready", sresp_r, 0);
    chk("lit_E_mresp_valid", mresp_v, 0);
    cyc();
    sresp_v = 1'b0;
    chk("lit_E_err_set", err, 1);
    repeat (3) cyc();
    chk("lit_E_err_sticky", err, 1);
    rst_n = 1'b0;
    #1 chk("lit_E_err_cleared", err, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
